// File: rtl/audio_position_master.sv
// audio_position_master
// Avalon-MM single-word master for the audio control slaves. A local command
// (one 32-bit read or write) becomes one Avalon transfer. Completion or a
// waitrequest timeout is reported on a one-cycle response strobe.
module audio_position_master #(
   parameter int ADDR_W         = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   // local command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [31:0]       cmd_writedata,
   // response side
   output logic              rsp_valid,
   output logic [31:0]       rsp_readdata,
   output logic              rsp_timeout,
   // Avalon-MM master
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read_n,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   // statistics
   output logic [15:0]       xfer_count,
   output logic [7:0]        timeout_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   // Timeout threshold as a 16-bit value; zero means the abort path is off.
   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

   state_t      state;
   logic        is_write;
   logic [15:0] wait_cnt;
   logic [15:0] wait_next;
   logic        timeout_hit;

   // Stall counter increments saturate so a disabled timeout never wraps.
   assign wait_next   = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
   // Abort once this stall cycle brings the count up to the threshold.
   assign timeout_hit = (TMO != 16'd0) && (wait_next == TMO);

   // Ready is a pure state decode so it tracks the FSM with no extra latency.
   assign cmd_ready = (state == IDLE);

   // Transfer FSM with all Avalon and response outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         is_write       <= 1'b0;
         wait_cnt       <= 16'd0;
         rsp_valid      <= 1'b0;
         rsp_readdata   <= 32'd0;
         rsp_timeout    <= 1'b0;
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_read_n     <= 1'b1;
         avm_writedata  <= 32'd0;
         xfer_count     <= 16'd0;
         timeout_count  <= 8'd0;
      end else begin
         // Response strobe is one cycle wide unless re-armed below.
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  avm_address    <= cmd_address;
                  avm_writedata  <= cmd_writedata;
                  is_write       <= cmd_write;
                  wait_cnt       <= 16'd0;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= ~cmd_write;
                  avm_read_n     <= cmd_write;
                  state          <= XFER;
               end
            end
            XFER: begin
               if (!avm_waitrequest) begin
                  // Slave accepted: completion always beats a pending timeout.
                  rsp_readdata   <= is_write ? 32'd0 : avm_readdata;
                  rsp_timeout    <= 1'b0;
                  xfer_count     <= xfer_count + 16'd1;
                  avm_chipselect <= 1'b0;
                  avm_write_n    <= 1'b1;
                  avm_read_n     <= 1'b1;
                  rsp_valid      <= 1'b1;
                  state          <= RESP;
               end else begin
                  wait_cnt <= wait_next;
                  if (timeout_hit) begin
                     rsp_readdata   <= 32'd0;
                     rsp_timeout    <= 1'b1;
                     if (timeout_count != 8'hFF)
                        timeout_count <= timeout_count + 8'd1;
                     avm_chipselect <= 1'b0;
                     avm_write_n    <= 1'b1;
                     avm_read_n     <= 1'b1;
                     rsp_valid      <= 1'b1;
                     state          <= RESP;
                  end
               end
            end
            RESP: begin
               // Strobes are already low; one turnaround cycle before IDLE.
               state <= IDLE;
            end
            default: begin
               avm_chipselect <= 1'b0;
               avm_write_n    <= 1'b1;
               avm_read_n     <= 1'b1;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_position_master.sv
// Bench for audio_position_master: directed vector table, multi-cycle corner
// sequences and randomized transfers checked against a transaction-level model.
module tb_audio_position_master;

   localparam int ADDR_W = 2;
   localparam int T      = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_address = '0;
   logic [31:0]       cmd_writedata = 32'd0;
   logic              rsp_valid;
   logic [31:0]       rsp_readdata;
   logic              rsp_timeout;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_chipselect;
   logic              avm_write_n;
   logic              avm_read_n;
   logic [31:0]       avm_writedata;
   logic [31:0]       avm_readdata = 32'd0;
   logic              avm_waitrequest = 1'b0;
   logic [15:0]       xfer_count;
   logic [7:0]        timeout_count;

   audio_position_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
      .rsp_valid(rsp_valid), .rsp_readdata(rsp_readdata), .rsp_timeout(rsp_timeout),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .xfer_count(xfer_count), .timeout_count(timeout_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: counters as the specification defines them.
   logic [15:0] m_xfer = 16'd0;
   int          m_tmo  = 0;

   typedef struct {
      logic              w;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      int                stalls;
      logic [31:0]       rdata;
      int                exp_cs;
      logic              exp_to;
      logic [31:0]       exp_rd;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Account a transfer outcome in the model counters.
   task automatic model_count(input logic to);
      if (to) m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255;
      else    m_xfer = m_xfer + 16'd1;
   endtask

   // One full transfer from IDLE. Slave stalls for 'stalls' chipselect cycles,
   // then returns rdata. Must be entered at a negedge with the DUT idle.
   task automatic do_xfer(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input int stalls, input logic [31:0] rdata,
                          input int exp_cs, input logic exp_to, input logic [31:0] exp_rd);
      int  cs, n;
      bit  got, bad;
      cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_writedata = d;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_writedata = $urandom;
      cs = 0; n = 0; got = 0; bad = 0;
      while (!got && n < 60) begin
         n++;
         if (rsp_valid) got = 1;
         else begin
            if (avm_chipselect) begin
               cs++;
               if (avm_address !== a || avm_write_n !== !w || avm_read_n !== w ||
                   (avm_write_n === 1'b0 && avm_read_n === 1'b0) ||
                   (w && avm_writedata !== d)) bad = 1;
               avm_waitrequest = (cs <= stalls);
               avm_readdata    = avm_waitrequest ? $urandom : rdata;
            end else begin
               avm_waitrequest = 1'b0;
            end
            @(negedge clk);
         end
      end
      avm_waitrequest = 1'b0;
      if (!got) begin
         chk("rsp_valid_within_bound", 32'd0, 32'd1);
         return;
      end
      chk("strobes_addr_data", 32'(bad), 32'd0);
      chk("chipselect_cycles", 32'(cs), 32'(exp_cs));
      chk("rsp_latency", 32'(n), 32'(exp_cs + 1));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      chk("rsp_readdata", rsp_readdata, exp_rd);
      chk("xfer_count", 32'(xfer_count), 32'(m_xfer));
      chk("timeout_count", 32'(timeout_count), 32'(m_tmo));
      @(negedge clk);
      chk("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_after_resp", 32'(cmd_ready), 32'd1);
      chk("rsp_readdata_held", rsp_readdata, exp_rd);
   endtask

   initial begin
      int acc_at[3];
      int acc;
      bit seen;
      logic [15:0] xc0;

      // Directed vectors: {w, addr, wdata, stalls, rdata, exp_cs, exp_to, exp_rd}
      vecs[0] = '{1'b1, 2'd0, 32'h0001_F400, 0,  32'h0,         1, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 2'd1, 32'h0,         3,  32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 2'd2, 32'h0,         99, 32'h1111_2222, 4, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 2'd3, 32'hA5A5_5A5A, 3,  32'hFFFF_FFFF, 4, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 2'd3, 32'h0,         4,  32'hCAFE_F00D, 4, 1'b1, 32'h0};
      vecs[5] = '{1'b0, 2'd0, 32'h0,         0,  32'h1234_5678, 1, 1'b0, 32'h1234_5678};

      // Reset state.
      repeat (2) @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_readdata", rsp_readdata, 32'd0);
      chk("reset_chipselect", 32'(avm_chipselect), 32'd0);
      chk("reset_write_n", 32'(avm_write_n), 32'd1);
      chk("reset_read_n", 32'(avm_read_n), 32'd1);
      chk("reset_writedata", avm_writedata, 32'd0);
      chk("reset_xfer_count", 32'(xfer_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < 6; i++) begin
         model_count(vecs[i].exp_to);
         do_xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].stalls, vecs[i].rdata,
                 vecs[i].exp_cs, vecs[i].exp_to, vecs[i].exp_rd);
      end

      // Back-to-back: cmd_valid held high, acceptances must be 3 cycles apart.
      xc0 = xfer_count;
      acc = 0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd1; cmd_writedata = 32'h100;
      for (int c = 0; c < 20 && acc < 3; c++) begin
         if (cmd_ready && cmd_valid) begin
            acc_at[acc] = c;
            acc++;
         end
         @(negedge clk);
         if (acc == 3) cmd_valid = 1'b0;
         else cmd_writedata = cmd_writedata + 32'd1;
      end
      cmd_valid = 1'b0;
      chk("b2b_accept_count", 32'(acc), 32'd3);
      chk("b2b_spacing_1", 32'(acc_at[1] - acc_at[0]), 32'd3);
      chk("b2b_spacing_2", 32'(acc_at[2] - acc_at[1]), 32'd3);
      repeat (3) @(negedge clk);
      chk("b2b_xfer_delta", 32'(xfer_count - xc0), 32'd3);
      m_xfer = m_xfer + 16'd3;

      // Randomized transfers against the model.
      for (int i = 0; i < 40; i++) begin
         logic              w;
         logic [ADDR_W-1:0] a;
         logic [31:0]       d, rd, erd;
         int                st, ecs;
         logic              eto;
         w   = 1'($urandom);
         a   = ADDR_W'($urandom);
         d   = $urandom;
         rd  = $urandom;
         st  = $urandom_range(0, 6);
         eto = (st >= T);
         ecs = eto ? T : st + 1;
         erd = (eto || w) ? 32'd0 : rd;
         model_count(eto);
         do_xfer(w, a, d, st, rd, ecs, eto, erd);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Reset in the middle of a stalled read.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2;
      avm_waitrequest = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("midreset_cs_before", 32'(avm_chipselect), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midreset_cs_drop", 32'(avm_chipselect), 32'd0);
      chk("midreset_read_n", 32'(avm_read_n), 32'd1);
      chk("midreset_write_n", 32'(avm_write_n), 32'd1);
      seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      reset_n = 1'b1;
      avm_waitrequest = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      chk("midreset_no_rsp", 32'(seen), 32'd0);
      chk("midreset_idle", 32'(cmd_ready), 32'd1);
      m_xfer = 16'd0; m_tmo = 0;
      model_count(1'b0);
      do_xfer(1'b1, 2'd1, 32'h0BAD_F00D, 0, 32'h0, 1, 1'b0, 32'h0);

      // 256 forced timeouts: counter must saturate at 0xFF.
      for (int i = 0; i < 256; i++) begin
         model_count(1'b1);
         do_xfer(1'b0, 2'd0, 32'h0, 1000, 32'h0, T, 1'b1, 32'h0);
      end
      chk("timeout_saturated", 32'(timeout_count), 32'hFF);

      // Wrap of xfer_count: load 0xFFFF directly instead of 65535 real transfers.
      force dut.xfer_count = 16'hFFFF;
      #1;
      release dut.xfer_count;
      m_xfer = 16'hFFFF;
      @(negedge clk);
      model_count(1'b0);
      do_xfer(1'b0, 2'd3, 32'h0, 1, 32'h7777_0000, 2, 1'b0, 32'h7777_0000);
      chk("xfer_count_wrapped", 32'(xfer_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
